multi_edge_detector: RTL

// - Multi-channel edge detector with per-channel runtime mode (rise/fall/both/off).
// - Optional glitch filter and sticky per-channel event flags with saturating edge counters.
// - Sits between raw sampled bus lines (SPI/UART/I2C taps) and the MITM control FSMs.
// - Consumers either poll pending/count or react to the single-cycle edge_pulse.
//

---
 rtl/multi_edge_detector.sv | 97 +++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - per-channel glitch-filtered edge detector with sticky flags and saturating counters
// Optional input synchronizer enabled by defining EDGE_DET_SYNC_EN.
module multi_edge_detector #(
   parameter int CHANNELS   = 4,
   parameter int FILTER_LEN = 0,
   parameter int CNT_W      = 8
) (
   input  logic                      sys_clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       sig,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS-1:0]       clr,
   output logic [CHANNELS-1:0]       edge_pulse,
   output logic [CHANNELS-1:0]       pending,
   output logic [CHANNELS*CNT_W-1:0] edge_cnt,
   output logic [CHANNELS-1:0]       cnt_sat
);

   localparam int FC_W = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;
   localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(FILTER_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CHANNELS-1:0] raw;
   logic [CHANNELS-1:0] level;
   logic [FC_W-1:0]     fc [CHANNELS];
   logic [CNT_W-1:0]    cnt [CHANNELS];
   logic [CHANNELS-1:0] accept;
   logic [CHANNELS-1:0] hit;

`ifdef EDGE_DET_SYNC_EN
   logic [CHANNELS-1:0] sync1;
   logic [CHANNELS-1:0] sync2;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync1 <= sig;
         sync2 <= sig;
      end else begin
         sync1 <= sig;
         sync2 <= sync1;
      end
   end

   assign raw = sync2;
`else
   assign raw = sig;
`endif

   // A level change is accepted once it has been seen on FILTER_LEN+1 consecutive samples.
   always_comb begin
      accept = '0;
      hit    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         accept[i] = (raw[i] != level[i]) && (fc[i] == FC_MAX);
         hit[i]    = accept[i] && ((raw[i] && mode[2*i]) || (!raw[i] && mode[2*i+1]));
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         level      <= sig;
         edge_pulse <= '0;
         pending    <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            fc[i]  <= '0;
            cnt[i] <= '0;
         end
      end else begin
         edge_pulse <= hit;
         pending    <= (pending & ~clr) | hit;
         for (int i = 0; i < CHANNELS; i++) begin
            if (raw[i] == level[i]) begin
               fc[i] <= '0;
            end else if (accept[i]) begin
               level[i] <= raw[i];
               fc[i]    <= '0;
            end else begin
               fc[i] <= fc[i] + FC_W'(1);
            end

            // A clear coinciding with an edge keeps that edge.
            if (clr[i]) begin
               cnt[i] <= hit[i] ? CNT_ONE : '0;
            end else if (hit[i] && (cnt[i] != CNT_MAX)) begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_out
      assign edge_cnt[CNT_W*g +: CNT_W] = cnt[g];
      assign cnt_sat[g]                 = (cnt[g] == CNT_MAX);
   end

endmodule
